// File: rtl/reg_file_wb.sv
// reg_file_wb: 32 x 32-bit integer register file with a write-back port,
// two combinational read ports and a pending-write scoreboard.
//
// Ports:
//   clk, rst_n                 clock and asynchronous active-low reset
//   wb_addr, wb_write, wb_data write port from MEM/WB
//   re1, raddr1 -> rdata1, busy1  read port 1 (busy1 = pending write on raddr1)
//   re2, raddr2 -> rdata2, busy2  read port 2
//   iss_valid, iss_addr        decode marks iss_addr as having a writer in flight
//   flush                      clears every pending mark
//
// Configuration macro: REG_FILE_WB_BYPASS_EN
//   defined   : a same-cycle write-back to the addressed register is forwarded
//               to the read port, and busy is forced low for that read.
//   undefined : the read returns the stored value; the new value appears on
//               the following cycle.
//
// x0 is hard-wired to zero: writes to it are dropped, its pending bit never
// sets, and reading it always returns 0 / not busy.

module reg_file_wb (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  wb_addr,
  input  logic        wb_write,
  input  logic [31:0] wb_data,
  input  logic        re1,
  input  logic [4:0]  raddr1,
  output logic [31:0] rdata1,
  output logic        busy1,
  input  logic        re2,
  input  logic [4:0]  raddr2,
  output logic [31:0] rdata2,
  output logic        busy2,
  input  logic        iss_valid,
  input  logic [4:0]  iss_addr,
  input  logic        flush
);

  logic [31:0] r_regs [0:31];
  logic [31:0] r_pend;

  logic [31:0] w_set;
  logic [31:0] w_clr;
  logic [31:0] w_pend_next;
  logic [31:0] w_rdata1;
  logic        w_busy1;
  logic [31:0] w_rdata2;
  logic        w_busy2;

  // Register storage: x0 is never written, so it stays at its reset value 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) begin
        r_regs[i] <= 32'd0;
      end
    end else if (wb_write && (wb_addr != 5'd0)) begin
      r_regs[wb_addr] <= wb_data;
    end
  end

  // Pending-vector next state: set beats clear on the same register (the newer
  // writer wins), flush beats everything, and bit 0 is masked off permanently.
  always_comb begin
    w_set = 32'd0;
    w_clr = 32'd0;
    if (iss_valid && (iss_addr != 5'd0)) begin
      w_set = 32'd1 << iss_addr;
    end else begin
      w_set = 32'd0;
    end
    if (wb_write) begin
      w_clr = 32'd1 << wb_addr;
    end else begin
      w_clr = 32'd0;
    end
    if (flush) begin
      w_pend_next = 32'd0;
    end else begin
      w_pend_next = ((r_pend & ~w_clr) | w_set) & ~32'd1;
    end
  end

  // Pending vector register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend <= 32'd0;
    end else begin
      r_pend <= w_pend_next;
    end
  end

  // Read port 1: zero when disabled, addressing x0, or in reset.
  always_comb begin
    w_rdata1 = 32'd0;
    w_busy1  = 1'b0;
    if (rst_n && re1 && (raddr1 != 5'd0)) begin
      w_rdata1 = r_regs[raddr1];
      w_busy1  = r_pend[raddr1];
`ifdef REG_FILE_WB_BYPASS_EN
      if (wb_write && (wb_addr == raddr1)) begin
        w_rdata1 = wb_data;
        w_busy1  = 1'b0;
      end else begin
        w_rdata1 = r_regs[raddr1];
        w_busy1  = r_pend[raddr1];
      end
`endif
    end else begin
      w_rdata1 = 32'd0;
      w_busy1  = 1'b0;
    end
  end

  // Read port 2: same behaviour as port 1.
  always_comb begin
    w_rdata2 = 32'd0;
    w_busy2  = 1'b0;
    if (rst_n && re2 && (raddr2 != 5'd0)) begin
      w_rdata2 = r_regs[raddr2];
      w_busy2  = r_pend[raddr2];
`ifdef REG_FILE_WB_BYPASS_EN
      if (wb_write && (wb_addr == raddr2)) begin
        w_rdata2 = wb_data;
        w_busy2  = 1'b0;
      end else begin
        w_rdata2 = r_regs[raddr2];
        w_busy2  = r_pend[raddr2];
      end
`endif
    end else begin
      w_rdata2 = 32'd0;
      w_busy2  = 1'b0;
    end
  end

  assign rdata1 = w_rdata1;
  assign busy1  = w_busy1;
  assign rdata2 = w_rdata2;
  assign busy2  = w_busy2;

endmodule

// File: tb/tb_reg_file_wb.sv
// Self-checking bench for reg_file_wb: a table of per-cycle vectors whose
// expected read results go through a queue, plus hand-written reset sequences.

module tb_reg_file_wb;

`ifdef REG_FILE_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic [4:0]  wb_addr;
  logic        wb_write;
  logic [31:0] wb_data;
  logic        re1;
  logic [4:0]  raddr1;
  logic [31:0] rdata1;
  logic        busy1;
  logic        re2;
  logic [4:0]  raddr2;
  logic [31:0] rdata2;
  logic        busy2;
  logic        iss_valid;
  logic [4:0]  iss_addr;
  logic        flush;

  int checks;
  int errors;

  reg_file_wb dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wb_addr  (wb_addr),
    .wb_write (wb_write),
    .wb_data  (wb_data),
    .re1      (re1),
    .raddr1   (raddr1),
    .rdata1   (rdata1),
    .busy1    (busy1),
    .re2      (re2),
    .raddr2   (raddr2),
    .rdata2   (rdata2),
    .busy2    (busy2),
    .iss_valid(iss_valid),
    .iss_addr (iss_addr),
    .flush    (flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        re1;
    logic [4:0]  a1;
    logic        re2;
    logic [4:0]  a2;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        iv;
    logic [4:0]  ia;
    logic        fl;
    logic [31:0] ed1;
    logic        eb1;
    logic [31:0] ed2;
    logic        eb2;
  } vec_t;

  typedef struct {
    int          idx;
    logic [31:0] ed1;
    logic        eb1;
    logic [31:0] ed2;
    logic        eb2;
  } exp_t;

  vec_t vt[$];
  exp_t sb[$];

  function automatic vec_t mk(input logic r1, input logic [4:0] a1,
                              input logic r2, input logic [4:0] a2,
                              input logic we, input logic [4:0] wa, input logic [31:0] wd,
                              input logic iv, input logic [4:0] ia, input logic fl,
                              input logic [31:0] ed1, input logic eb1,
                              input logic [31:0] ed2, input logic eb2);
    vec_t v;
    v.re1 = r1; v.a1 = a1; v.re2 = r2; v.a2 = a2;
    v.we = we; v.wa = wa; v.wd = wd; v.iv = iv; v.ia = ia; v.fl = fl;
    v.ed1 = ed1; v.eb1 = eb1; v.ed2 = ed2; v.eb2 = eb2;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    wb_addr = 5'd0; wb_write = 1'b0; wb_data = 32'd0;
    re1 = 1'b0; raddr1 = 5'd0; re2 = 1'b0; raddr2 = 5'd0;
    iss_valid = 1'b0; iss_addr = 5'd0; flush = 1'b0;
  endtask

  // Drive one vector on the falling edge, push its expectation, then sample
  // the combinational outputs before the next rising edge commits it.
  task automatic apply(input int idx, input vec_t v);
    exp_t e;
    exp_t got;
    string tag;
    @(negedge clk);
    re1 = v.re1; raddr1 = v.a1; re2 = v.re2; raddr2 = v.a2;
    wb_write = v.we; wb_addr = v.wa; wb_data = v.wd;
    iss_valid = v.iv; iss_addr = v.ia; flush = v.fl;
    e.idx = idx; e.ed1 = v.ed1; e.eb1 = v.eb1; e.ed2 = v.ed2; e.eb2 = v.eb2;
    sb.push_back(e);
    #2;
    got = sb.pop_front();
    tag = $sformatf("v%0d", got.idx);
    chk({tag, " rdata1"}, rdata1, got.ed1);
    chk({tag, " busy1"},  {31'd0, busy1}, {31'd0, got.eb1});
    chk({tag, " rdata2"}, rdata2, got.ed2);
    chk({tag, " busy2"},  {31'd0, busy2}, {31'd0, got.eb2});
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    idle_inputs();

    // Reset state, read enabled on live addresses.
    re1 = 1'b1; raddr1 = 5'd5; re2 = 1'b1; raddr2 = 5'd31;
    repeat (2) @(posedge clk);
    #1;
    chk("reset rdata1", rdata1, 32'd0);
    chk("reset busy1", {31'd0, busy1}, 32'd0);
    chk("reset rdata2", rdata2, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    //        re1 a1     re2 a2     we  wa     wd             iv  ia     fl    ed1 eb1  ed2 eb2
    vt.push_back(mk(1'b1, 5'd5, 1'b1, 5'd7, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0));
    vt.push_back(mk(1'b1, 5'd5, 1'b0, 5'd5, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 1'b0,
                    BYP ? 32'hDEADBEEF : 32'd0, 1'b0, 32'd0, 1'b0));
    vt.push_back(mk(1'b1, 5'd5, 1'b1, 5'd5, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0,
                    32'hDEADBEEF, 1'b0, 32'hDEADBEEF, 1'b0));
    vt.push_back(mk(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 32'h12345678, 1'b0, 5'd0, 1'b0,
                    32'd0, 1'b0, 32'd0, 1'b0));
    vt.push_back(mk(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0,
                    32'd0, 1'b0, 32'd0, 1'b0));
    vt.push_back(mk(1'b1, 5'd0, 1'b1, 5'd7, 1'b1, 5'd7, 32'hA5A5A5A5, 1'b0, 5'd0, 1'b0,
                    32'd0, 1'b0, BYP ? 32'hA5A5A5A5 : 32'd0, 1'b0));
    vt.push_back(mk(1'b1, 5'd5, 1'b1, 5'd7, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0,
                    32'hDEADBEEF, 1'b0, 32'hA5A5A5A5, 1'b0));
    // x3 scoreboard sequence.
    vt.push_back(mk(1'b1, 5'd3, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 1'b0,
                    32'd0, 1'b0, 32'd0, 1'b0));
    vt.push_back(mk(1'b1, 5'd3, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0,
                    32'd0, 1'b1, 32'd0, 1'b0));
    vt.push_back(mk(1'b1, 5'd9, 1'b1, 5'd3, 1'b1, 5'd3, 32'h33, 1'b1, 5'd3, 1'b0,
                    32'd0, 1'b0, BYP ? 32'h33 : 32'd0, !BYP));
    vt.push_back(mk(1'b1, 5'd3, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0,
                    32'h33, 1'b1, 32'd0, 1'b0));
    vt.push_back(mk(1'b1, 5'd3, 1'b0, 5'd0, 1'b1, 5'd3, 32'h44, 1'b0, 5'd0, 1'b0,
                    BYP ? 32'h44 : 32'h33, !BYP, 32'd0, 1'b0));
    vt.push_back(mk(1'b1, 5'd3, 1'b1, 5'd7, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0,
                    32'h44, 1'b0, 32'hA5A5A5A5, 1'b0));
    // Clear of a non-pending register is harmless; build x1, x2, x9 pending.
    vt.push_back(mk(1'b1, 5'd1, 1'b0, 5'd6, 1'b1, 5'd6, 32'h66, 1'b1, 5'd1, 1'b0,
                    32'd0, 1'b0, 32'd0, 1'b0));
    vt.push_back(mk(1'b1, 5'd1, 1'b1, 5'd6, 1'b0, 5'd0, 32'd0, 1'b1, 5'd2, 1'b0,
                    32'd0, 1'b1, 32'h66, 1'b0));
    vt.push_back(mk(1'b1, 5'd6, 1'b1, 5'd2, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 1'b0,
                    32'h66, 1'b0, 32'd0, 1'b1));
    // Flush with simultaneous issue of x4 and a write of x8.
    vt.push_back(mk(1'b1, 5'd9, 1'b1, 5'd1, 1'b1, 5'd8, 32'h88, 1'b1, 5'd4, 1'b1,
                    32'd0, 1'b1, 32'd0, 1'b1));
    vt.push_back(mk(1'b1, 5'd4, 1'b1, 5'd9, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0,
                    32'd0, 1'b0, 32'd0, 1'b0));
    vt.push_back(mk(1'b1, 5'd1, 1'b1, 5'd2, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0,
                    32'd0, 1'b0, 32'd0, 1'b0));
    vt.push_back(mk(1'b1, 5'd8, 1'b0, 5'd2, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0,
                    32'h88, 1'b0, 32'd0, 1'b0));
    // Independent set of x13 and clear of x12 on the same edge.
    vt.push_back(mk(1'b1, 5'd12, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd12, 1'b0,
                    32'd0, 1'b0, 32'd0, 1'b0));
    vt.push_back(mk(1'b1, 5'd13, 1'b1, 5'd31, 1'b1, 5'd12, 32'hC, 1'b1, 5'd13, 1'b0,
                    32'd0, 1'b0, 32'd0, 1'b0));
    vt.push_back(mk(1'b1, 5'd12, 1'b1, 5'd13, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0,
                    32'hC, 1'b0, 32'd0, 1'b1));
    // Issue of x0 never marks it; x0 reads 0 even with a write targeting it.
    vt.push_back(mk(1'b0, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd0, 1'b0,
                    32'd0, 1'b0, 32'd0, 1'b0));
    // x10 = 0x55 and pending, for the reset sequence.
    vt.push_back(mk(1'b1, 5'd10, 1'b0, 5'd0, 1'b1, 5'd10, 32'h55, 1'b1, 5'd10, 1'b0,
                    BYP ? 32'h55 : 32'd0, 1'b0, 32'd0, 1'b0));
    vt.push_back(mk(1'b1, 5'd10, 1'b1, 5'd10, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0,
                    32'h55, 1'b1, 32'h55, 1'b1));

    for (int i = 0; i < vt.size(); i++) begin
      apply(i, vt[i]);
    end

    // Reset pulsed between edges clears x10 data and pending immediately.
    @(negedge clk);
    idle_inputs();
    re1 = 1'b1; raddr1 = 5'd10; re2 = 1'b1; raddr2 = 5'd10;
    #1;
    chk("pre-reset rdata1", rdata1, 32'h55);
    rst_n = 1'b0;
    #1;
    chk("async reset rdata1", rdata1, 32'd0);
    chk("async reset busy1", {31'd0, busy1}, 32'd0);
    chk("async reset busy2", {31'd0, busy2}, 32'd0);

    // Write, issue and flush during reset are ignored.
    wb_write = 1'b1; wb_addr = 5'd11; wb_data = 32'h77;
    iss_valid = 1'b1; iss_addr = 5'd11;
    raddr2 = 5'd11;
    @(posedge clk);
    #1;
    chk("in-reset rdata2", rdata2, 32'd0);
    @(negedge clk);
    idle_inputs();
    rst_n = 1'b1;
    re1 = 1'b1; raddr1 = 5'd11; re2 = 1'b1; raddr2 = 5'd10;
    #1;
    chk("post-reset x11 rdata", rdata1, 32'd0);
    chk("post-reset x11 busy", {31'd0, busy1}, 32'd0);
    chk("post-reset x10 rdata", rdata2, 32'd0);

    // First edge after reset release performs a write.
    wb_write = 1'b1; wb_addr = 5'd11; wb_data = 32'h99;
    @(negedge clk);
    wb_write = 1'b0;
    #1;
    chk("resume write x11", rdata1, 32'h99);

    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard drain: got %0d leftover expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_file_wb.md
REG_FILE_WB -- requirements
Module: reg_file_wb

Interface
REQ-001 SHALL use one clock and asynchronous active-low reset: `clk  in  1  rising-edge clock`; `rst_n  in  1  asynchronous active-low reset`.
REQ-002 SHALL have write port from MEM/WB: `wb_addr  in  5  destination register`; `wb_write  in  1  write enable`; `wb_data  in  32  write data`.
REQ-003 SHALL have read port 1: `re1  in  1  read enable`; `raddr1  in  5  source address`; `rdata1  out  32  read data`; `busy1  out  1  raddr1 has pending write`.
REQ-004 SHALL have read port 2, identical to port 1: `re2`, `raddr2`, `rdata2`, `busy2`.
REQ-005 SHALL have scoreboard issue and flush: `iss_valid  in  1  decode issues a writer`; `iss_addr  in  5  its rd`; `flush  in  1  clear all pending marks`.

Function
REQ-006 SHALL hold 32 x 32-bit registers; x0 reads 0 always, and writes to x0 are discarded.
REQ-007 SHALL write `wb_data` to `regs[wb_addr]` on the rising clk when `wb_write`=1 and `wb_addr`!=0.
REQ-008 SHALL drive reads combinationally, with zero cycles latency.
REQ-009 SHALL drive `rdataN`=0 and `busyN`=0 when `reN`=0.
REQ-010 SHALL drive `rdataN`=0 and `busyN`=0 when `raddrN`=0, regardless of `reN`.
REQ-011 SHALL maintain a 32-bit pending vector: bit r set when `iss_valid`=1 and `iss_addr`=r!=0, cleared when `wb_write`=1 and `wb_addr`=r.
REQ-012 SHALL give set priority over clear on the same edge for the same register (newer writer wins).
REQ-013 SHALL let independent set and clear of different registers both take effect on the same edge.
REQ-014 SHALL clear the whole pending vector on the edge where `flush`=1, overriding any simultaneous set; the write in REQ-007 still occurs.
REQ-015 SHALL drive `busyN` = `pending[raddrN]` after bypass adjustment per Configuration.
REQ-016 SHALL keep bit 0 of the pending vector 0 permanently.
REQ-017 SHALL ignore a clear for a register whose pending bit is 0, with no error.

Reset
REQ-018 SHALL asynchronously clear all 32 registers and the pending vector while `rst_n`=0, independent of clk.
REQ-019 SHALL drive every read output to 0 during reset.
REQ-020 SHALL ignore writes, issues and flush on edges while `rst_n`=0.
REQ-021 SHALL, when reset is asserted mid-operation, lose any in-flight write at that edge.
REQ-022 SHALL resume normal operation on the first rising clk after `rst_n` deasserts.

Configuration
REQ-023 SHALL support the compile-time macro `REG_FILE_WB_BYPASS_EN`.
REQ-024 SHALL, with `REG_FILE_WB_BYPASS_EN` defined and when `wb_write`=1, `wb_addr`=`raddrN`!=0 and `reN`=1, drive `rdataN`=`wb_data` in the same cycle and force `busyN`=0.
REQ-025 SHALL, without `REG_FILE_WB_BYPASS_EN`, return the stored (old) value and un-adjusted `busyN` in the write cycle; the new value is visible from the next cycle.

Verification
REQ-026 SHALL pass: write x5=0xDEADBEEF, next cycle re1=1, raddr1=5 -> rdata1=0xDEADBEEF, busy1=0.
REQ-027 SHALL pass: write x0=0x12345678, then read x0 on both ports -> rdata1=rdata2=0.
REQ-028 SHALL pass: same-cycle write x7=0xA5A5A5A5 and read raddr2=7 -> with bypass rdata2=0xA5A5A5A5, without bypass the old value (0 after reset).
REQ-029 SHALL pass: issue x3, next cycle read x3 -> busy1=1; then simultaneous wb_write x3 and iss_valid x3 -> busy1 stays 1; then wb_write x3 alone -> busy1=0.
REQ-030 SHALL pass: mark x1, x2, x9 pending, then flush=1 with iss_valid x4 on the same edge -> all busy reads 0, x4 not pending.
REQ-031 SHALL pass: write x10=0x55 and mark x10 pending, then pulse rst_n=0 between edges -> immediately rdata=0, busy=0 for x10.
